// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and helpers for the LED indicator controller.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_ACT   = 2'd3
    } led_mode_e;

    typedef enum logic {
        ST_LAMP = 1'b0,
        ST_RUN  = 1'b1
    } led_state_e;

    // Out-of-range divider selects saturate at the prescaler MSB.
    function automatic int clamp_sel(input int d, input int cnt_w);
        return (d >= cnt_w) ? (cnt_w - 1) : d;
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_stretch.sv
`default_nettype none
// ============================================================================
// Module      : led_stretch
// Description : Retriggerable activity pulse stretcher for one LED channel.
// Revision    : 1.0 - initial release
// ============================================================================
module led_stretch #(
    parameter int CNT_W = 27,
    parameter int EXP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_act,
    input  logic             i_event,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stretch;
    logic [CNT_W-1:0] w_load;

    assign w_load = c_one << i_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stretch <= '0;
        end else if (!(i_run && i_act)) begin
            r_stretch <= '0;
        end else if (i_event) begin
            r_stretch <= w_load;
        end else if (r_stretch != '0) begin
            r_stretch <= r_stretch - c_one;
        end
    end

    // The event term bypasses the counter so the LED lights on the sampling edge.
    assign o_term = i_event | (r_stretch != '0);

endmodule : led_stretch
`default_nettype wire

// File: rtl/led_indicator.sv
`default_nettype none
// ============================================================================
// Module      : led_indicator
// Description : N-channel LED controller (OFF/ON/BLINK/ACTIVITY) with lamp test.
// Revision    : 1.0 - initial release
// ============================================================================
module led_indicator
    import led_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CNT_W  = 27,
    parameter int SEL_W  = 5,
    parameter int LAMP_W = 24
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst_n,
    input  logic [2*NCH-1:0]     i_mode,
    input  logic [SEL_W*NCH-1:0] i_div_sel,
    input  logic [NCH-1:0]       i_event,
    output logic [NCH-1:0]       o_led,
    output logic                 o_lamp_done
);

    localparam int EXP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    led_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LAMP_W-1:0] r_lamp_cnt;
    logic [NCH-1:0]    r_led;
    logic              r_lamp_done;

    logic              w_run;
    logic [NCH-1:0]    w_act_term;
    logic [NCH-1:0]    w_next;

    assign w_run = (r_state == ST_RUN);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [SEL_W-1:0] w_sel;
            logic [EXP_W-1:0] w_exp;
            led_mode_e        w_mode;

            assign w_sel  = i_div_sel[SEL_W*gi +: SEL_W];
            assign w_exp  = EXP_W'(clamp_sel(int'(w_sel), CNT_W));
            assign w_mode = led_mode_e'(i_mode[2*gi +: 2]);

            led_stretch #(
                .CNT_W (CNT_W),
                .EXP_W (EXP_W)
            ) u_stretch (
                .clk     (i_sys_clk),
                .rst_n   (i_sys_rst_n),
                .i_run   (w_run),
                .i_act   (w_mode == LED_ACT),
                .i_event (i_event[gi]),
                .i_exp   (w_exp),
                .o_term  (w_act_term[gi])
            );

            assign w_next[gi] = (w_mode == LED_ON)
                              | ((w_mode == LED_BLINK) & r_cnt[w_exp])
                              | ((w_mode == LED_ACT)   & w_act_term[gi]);
        end
    endgenerate

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state     <= ST_LAMP;
            r_cnt       <= '0;
            r_lamp_cnt  <= '0;
            r_led       <= '0;
            r_lamp_done <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
                ST_LAMP: begin
                    r_lamp_cnt <= r_lamp_cnt + 1'b1;
                    r_led      <= '1;
                    if (r_lamp_cnt == '1) begin
                        r_state     <= ST_RUN;
                        r_lamp_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_led <= w_next;
                end
                default: begin
                    r_state <= ST_LAMP;
                end
            endcase
        end
    end

    assign o_led       = r_led;
    assign o_lamp_done = r_lamp_done;

endmodule : led_indicator
`default_nettype wire

// File: tb/tb_led_indicator.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_indicator
// Description : Randomised self-checking bench for led_indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_indicator;

    localparam int NCH    = 4;
    localparam int CNT_W  = 10;
    localparam int SEL_W  = 5;
    localparam int LAMP_W = 4;
    localparam int LAMP_CYC = 1 << LAMP_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [2*NCH-1:0]     mode = '0;
    logic [SEL_W*NCH-1:0] div_sel = '0;
    logic [NCH-1:0]       ev = '0;
    logic [NCH-1:0]       led;
    logic                 lamp_done;

    int checks = 0;
    int failures = 0;

    // Reference state: edges since reset release and each channel's last lit edge.
    int n = 0;
    int deadline [NCH];
    logic [NCH-1:0] exp_led = '0;
    logic           exp_done = 1'b0;

    led_indicator #(
        .NCH    (NCH),
        .CNT_W  (CNT_W),
        .SEL_W  (SEL_W),
        .LAMP_W (LAMP_W)
    ) u_dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .i_mode      (mode),
        .i_div_sel   (div_sel),
        .i_event     (ev),
        .o_led       (led),
        .o_lamp_done (lamp_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", tag, obs, expv, $time, n);
        end
    endtask

    function automatic int eff(input int d);
        return (d > CNT_W - 1) ? CNT_W - 1 : d;
    endfunction

    task automatic model_reset();
        n        = 0;
        exp_led  = '0;
        exp_done = 1'b0;
        for (int c = 0; c < NCH; c++) deadline[c] = 0;
    endtask

    // Expected outputs after edge n, computed from the inputs present at that edge.
    task automatic model_edge();
        n++;
        exp_done = (n >= LAMP_CYC);
        if (n <= LAMP_CYC) begin
            exp_led = '1;
            for (int c = 0; c < NCH; c++) deadline[c] = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                int m;
                int e;
                m = int'(mode[2*c +: 2]);
                e = eff(int'(div_sel[SEL_W*c +: SEL_W]));
                if (m != 3) deadline[c] = 0;
                case (m)
                    0: exp_led[c] = 1'b0;
                    1: exp_led[c] = 1'b1;
                    2: exp_led[c] = (((n - 1) % (1 << CNT_W)) >> e) & 1;
                    default: begin
                        if (ev[c]) begin
                            exp_led[c]  = 1'b1;
                            deadline[c] = n + (1 << e);
                        end else begin
                            exp_led[c] = (n <= deadline[c]);
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("led", 32'(led), 32'(exp_led));
        chk("lamp_done", 32'(lamp_done), 32'(exp_done));
    endtask

    task automatic set_ch(input int c, input int m, input int d);
        mode[2*c +: 2]          = 2'(m);
        div_sel[SEL_W*c +: SEL_W] = SEL_W'(d);
    endtask

    task automatic random_run(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if ($urandom_range(29) == 0) begin
                int c;
                c = int'($urandom_range(NCH - 1));
                set_ch(c, int'($urandom_range(3)),
                       ($urandom_range(7) == 0) ? int'($urandom_range(31)) : int'($urandom_range(5)));
            end
            for (int c = 0; c < NCH; c++) ev[c] = ($urandom_range(9) == 0);
            step();
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_lamp_done", 32'(lamp_done), 32'd0);

        // Lamp test followed by static ON/OFF pattern.
        set_ch(0, 1, 0);
        set_ch(1, 0, 0);
        set_ch(2, 1, 0);
        set_ch(3, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (LAMP_CYC + 2048) step();
        chk("static_pattern", 32'(led), 32'h5);

        // Blink d=2, blink clamped d=31, activity d=3 with retrigger.
        set_ch(0, 2, 2);
        set_ch(3, 2, 31);
        set_ch(1, 3, 3);
        repeat (5) step();
        ev[1] = 1'b1; step();
        ev[1] = 1'b0; repeat (4) step();
        ev[1] = 1'b1; step();
        ev[1] = 1'b0; repeat (12) step();

        // Switch away from ACTIVITY mid-stretch, then back without an event.
        ev[1] = 1'b1; step();
        ev[1] = 1'b0; repeat (3) step();
        set_ch(1, 0, 3); step();
        set_ch(1, 3, 3); repeat (6) step();
        repeat (1100) step();

        // Held event keeps the LED lit, release starts the stretch.
        set_ch(2, 3, 1);
        ev[2] = 1'b1; repeat (6) step();
        ev[2] = 1'b0; repeat (6) step();

        random_run(3000);

        // Asynchronous reset away from the clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_lamp_done", 32'(lamp_done), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        random_run(LAMP_CYC + 600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_led_indicator
`default_nettype wire
